// File: rtl/msf_pkg.sv
// Shared types and helpers for the MSF bit slicer: FSM states, decoded-second
// record, saturating magnitude and the slot-pattern decoder.
package msf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLOTS = 2'd1,
    ST_DONE  = 2'd2
  } msf_state_t;

  localparam int MSF_NUM_SLOTS = 5;

  typedef struct packed {
    logic a;
    logic b;
    logic minute;
    logic err;
  } msf_sec_t;

  // -32768 has no positive counterpart, so it clips to 32767.
  function automatic logic [15:0] msf_mag(input logic signed [15:0] x);
    logic signed [15:0] neg;
    neg = -x;
    if (x == 16'sh8000) return 16'h7fff;
    else if (x[15])     return $unsigned(neg);
    else                return $unsigned(x);
  endfunction

  // s[i] = 1 when slot i was carrier-off.
  function automatic msf_sec_t msf_decode(input logic [MSF_NUM_SLOTS-1:0] s);
    msf_sec_t r;
    r = '0;
    if (!s[0])            r.err    = 1'b1;
    else if (&s)          r.minute = 1'b1;
    else if (s[3] | s[4]) r.err    = 1'b1;
    else begin
      r.a = s[1];
      r.b = s[2];
    end
    return r;
  endfunction

endpackage

// File: rtl/msf_peak_tracker.sv
// Carrier-on level tracker: loads |average| when it exceeds the held peak,
// otherwise decays the peak by peak >> DECAY_SHIFT on every valid strobe.
module msf_peak_tracker
  import msf_pkg::*;
#(
  parameter int DECAY_SHIFT = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic signed [15:0] average_i,
  output logic        [15:0] peak_o
);

  logic [15:0] mag;
  logic [15:0] peak_q, peak_d;

  assign mag = msf_mag(average_i);

  always_comb begin
    if (mag > peak_q) peak_d = mag;
    else              peak_d = peak_q - (peak_q >> DECAY_SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          peak_q <= '0;
    else if (valid_i) peak_q <= peak_d;
  end

  assign peak_o = peak_q;

endmodule

// File: rtl/msf_bit_slicer.sv
// MSF bit slicer: splits each second into five 100 ms slots, takes an off/on
// decision mid-slot and decodes bits A/B. Define MSF_SLICER_PEAK_TRACK_EN for
// the adaptive threshold; otherwise threshold_fixed is used.
module msf_bit_slicer
  import msf_pkg::*;
#(
  parameter int SLOT_SAMPLES = 2500,
  parameter int DECAY_SHIFT  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] average,
  input  logic               valid,
  input  logic               one_sec_marker,
  input  logic        [15:0] threshold_fixed,
  output logic               bit_a,
  output logic               bit_b,
  output logic               minute_marker,
  output logic               frame_err,
  output logic               sec_valid,
  output logic        [15:0] carrier_level
);

  localparam int             CW        = $clog2(SLOT_SAMPLES);
  localparam logic [CW-1:0]  HALF      = CW'(SLOT_SAMPLES / 2);
  localparam logic [CW-1:0]  LAST      = CW'(SLOT_SAMPLES - 1);
  localparam logic [2:0]     LAST_SLOT = 3'(MSF_NUM_SLOTS - 1);

  logic [15:0] thr;
  logic        off;

`ifdef MSF_SLICER_PEAK_TRACK_EN
  logic [15:0] peak;
  logic        unused_thr_fixed;

  msf_peak_tracker #(.DECAY_SHIFT(DECAY_SHIFT)) u_peak (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid),
    .average_i (average),
    .peak_o    (peak)
  );

  assign carrier_level    = peak;
  assign thr              = peak >> 1;
  assign unused_thr_fixed = ^threshold_fixed;
`else
  localparam int unused_decay = DECAY_SHIFT;
  assign carrier_level = '0;
  assign thr           = threshold_fixed;
`endif

  // thr is the registered level from before this strobe's tracker update.
  assign off = msf_mag(average) < thr;

  msf_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        slot_q, slot_d;
  logic [3:0]        s_q, s_d;
  msf_sec_t          res_q, res_d;
  logic              sv_q, sv_d;
  logic              mark_q;
  logic              rise;

  assign rise = one_sec_marker & ~mark_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    s_d     = s_q;
    res_d   = res_q;
    sv_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (rise) begin
          // A strobe coinciding with the edge is sample 0 of the new frame.
          state_d = ST_SLOTS;
          cnt_d   = valid ? CW'(1) : '0;
          slot_d  = '0;
          s_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SLOTS: begin
        if (rise) begin
          res_d     = '0;
          res_d.err = 1'b1;
          sv_d      = 1'b1;
          cnt_d     = valid ? CW'(1) : '0;
          slot_d    = '0;
          s_d       = '0;
        end else if (valid) begin
          if (cnt_q == HALF) begin
            if (slot_q == LAST_SLOT) begin
              res_d   = msf_decode({off, s_q});
              sv_d    = 1'b1;
              state_d = ST_DONE;
            end else begin
              s_d[slot_q[1:0]] = off;
            end
          end
          if (cnt_q == LAST) begin
            cnt_d  = '0;
            slot_d = slot_q + 3'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      s_q     <= '0;
      res_q   <= '0;
      sv_q    <= 1'b0;
      mark_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      s_q     <= s_d;
      res_q   <= res_d;
      sv_q    <= sv_d;
      mark_q  <= one_sec_marker;
    end
  end

  assign bit_a         = res_q.a;
  assign bit_b         = res_q.b;
  assign minute_marker = res_q.minute;
  assign frame_err     = res_q.err;
  assign sec_valid     = sv_q;

endmodule

// File: doc/msf_bit_slicer.md
# msf_bit_slicer

Downstream of the IQ averager in the MSF receive chain. Consumes the averager's signed amplitude stream (`average`/`valid`) plus the one-second marker, tracks the carrier-on level and slices each second into five 100 ms slots. Emits per-second MSF bits A and B, a minute-marker flag and a frame-error flag for the time-code assembler.

## Interface
- `SLOT_SAMPLES`, 2500: averager `valid` strobes per 100 ms slot (40 µs rate); must be ≥ 2.
- `DECAY_SHIFT`, 10: peak-tracker decay, peak -= peak >> DECAY_SHIFT per strobe.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `average`  in  16  signed averaged amplitude from the averager.
- `valid`  in  1  one-cycle strobe qualifying `average`.
- `one_sec_marker`  in  1  level or pulse; the rising edge marks second start.
- `threshold_fixed`  in  16  unsigned carrier-off threshold; used only when the peak tracker is compiled out.
- `bit_a`  out  1  MSF bit A of the last completed second.
- `bit_b`  out  1  MSF bit B of the last completed second.
- `minute_marker`  out  1  last second was the 500 ms minute marker.
- `frame_err`  out  1  last second's slot pattern was illegal or truncated.
- `sec_valid`  out  1  one-cycle strobe; the four flags above are updated on this cycle.
- `carrier_level`  out  16  current tracked peak, unsigned.

## Operation
- Magnitude: `mag = |average|`, saturating at -32768 → 32767. A sample is "off" when `mag < threshold`.
- Threshold: `carrier_level >> 1` (tracker enabled) or `threshold_fixed`.
- States (3):
  - IDLE: wait for a marker rising edge.
  - SLOTS: count `valid` strobes. Slot index 0..4 and in-slot count 0..SLOT_SAMPLES-1. The off/on decision for each slot is captured on the strobe with in-slot count == SLOT_SAMPLES/2 (integer).
  - DONE: one cycle. Decode, assert `sec_valid`, return to IDLE.
- Decode, with s0..s4 = 1 when the slot is off:
  - s0 = 0 → frame_err.
  - s0..s4 all 1 → minute_marker = 1, A = B = 0.
  - Otherwise A = s1, B = s2; s3 or s4 = 1 → frame_err.
- On frame_err, A, B and minute_marker are 0.
- SLOTS → DONE once the slot-4 decision strobe has been captured. Strobes after that in the same second are ignored.
- Marker edge while in SLOTS: abort the frame. Emit `sec_valid` with frame_err = 1 next cycle, then start a new frame from slot 0.
- Marker edge and `valid` on the same cycle: the strobe is sample 0 of the new frame.
- Marker edge while in DONE: the result is emitted normally and the new frame starts at once (no IDLE cycle).
- Counters are sized by `$clog2(SLOT_SAMPLES)` and never wrap within a frame.

## Timing
- Reset values: every output is 0, `carrier_level` is 0, state is IDLE, the marker edge detector is 0.
- Marker edge detect: registered. The frame starts on the cycle after the rising edge is seen.
- Latency:
  - `sec_valid` is high exactly 1 cycle after the slot-4 decision strobe.
  - On abort, `sec_valid` is high 1 cycle after the marker edge is detected.
- Result flags hold until the next `sec_valid`.
- `carrier_level` updates 1 cycle after each `valid`. Rule: if `mag > peak`, load `mag`; otherwise decay.
- Decisions use the threshold registered before the current strobe's update.
- `rst` asserted mid-frame: immediate return to reset values, and no `sec_valid` is emitted.

## Configuration
- `MSF_SLICER_PEAK_TRACK_EN` defined: adaptive threshold = `carrier_level >> 1`; `threshold_fixed` is ignored.
- Not defined: the tracker is removed, `carrier_level` is tied to 0, and `threshold_fixed` is the threshold.

## Structure
- Package `msf_pkg` holds:
  - the state enum (IDLE, SLOTS, DONE);
  - `MSF_NUM_SLOTS = 5`;
  - the decoded-second struct {a, b, minute, err}.
- Sub-module `msf_peak_tracker` contains the magnitude, saturation and peak/decay logic. It is instantiated only under the macro.

## Test plan
All scenarios use SLOT_SAMPLES = 4, DECAY_SHIFT = 4 and the tracker enabled. Carrier is primed at 1000, so the threshold is ≈500.
- Off 1 slot (amp 0), then 1000 for the remaining slots → `sec_valid`, A = 0, B = 0, err = 0.
- Off slots 0-1, then on → A = 1, B = 0. Off, on, off, on, on → A = 0, B = 1. Off slots 0-2 → A = 1, B = 1.
- Off for all 5 slots → minute_marker = 1, A = B = 0, err = 0.
- Slot 0 on (1000) → frame_err = 1. Off slots 0 and 3 only → frame_err = 1.
- Second marker after 2 slots → abort `sec_valid` with err = 1 one cycle after edge detection; the next full second decodes correctly.
- `average` = -32768 → `carrier_level` = 32767. Feeding 0 decays it to 30720 after one strobe. `rst` asserted mid-SLOTS → all outputs 0 and no strobe.
